// File: rtl/axis_pkt_pkg.sv
// Shared types and helpers for the AXI-Stream packetizer.
package axis_pkt_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StSend  = 2'd1,
    StFlush = 2'd2
  } pkt_state_e;

  // Ceiling log2; returns 0 for values <= 1.
  function automatic int unsigned clogb2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((64'd1 << res) < 64'(value)) begin
      res = res + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count.
module axis_sync_fifo
  import axis_pkt_pkg::*;
#(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [Width-1:0]          wdata_i,
  input  logic                      push_i,
  input  logic                      pop_i,
  output logic [Width-1:0]          rdata_o,
  output logic [clogb2(Depth):0]    count_o
);

  localparam int unsigned AddrW = clogb2(Depth);
  localparam int unsigned CntW  = AddrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;

  // Pointers wrap naturally because Depth is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) begin
      wr_ptr_d = wr_ptr_q + AddrW'(1);
    end
    if (pop_i) begin
      rd_ptr_d = rd_ptr_q + AddrW'(1);
    end
    if (push_i && !pop_i) begin
      count_d = count_q + CntW'(1);
    end else if (pop_i && !push_i) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/axis_packetizer.sv
// Frames an unframed AXI-Stream into fixed-length packets, flushing a partial
// packet with an early TLAST after an input-idle timeout.
module axis_packetizer
  import axis_pkt_pkg::*;
#(
  parameter int unsigned C_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned C_PKT_LEN          = 8,
  parameter int unsigned C_FIFO_DEPTH       = 16,
  parameter int unsigned C_FLUSH_TIMEOUT    = 64
) (
  input  logic                              AXIS_ACLK,
  input  logic                              AXIS_ARESET,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]     S_AXIS_TDATA,
  input  logic                              S_AXIS_TVALID,
  output logic                              S_AXIS_TREADY,
  output logic [C_AXIS_TDATA_WIDTH-1:0]     M_AXIS_TDATA,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0]   M_AXIS_TSTRB,
  output logic                              M_AXIS_TVALID,
  output logic                              M_AXIS_TLAST,
  input  logic                              M_AXIS_TREADY,
  output logic [clogb2(C_FIFO_DEPTH):0]     fifo_count,
  output logic [15:0]                       pkt_count
);

  localparam int unsigned CntW    = clogb2(C_FIFO_DEPTH) + 1;
  localparam bit          FlushEn = (C_FLUSH_TIMEOUT != 0);
  localparam int unsigned TmrW    = FlushEn ? clogb2(C_FLUSH_TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] PktLenC = CntW'(C_PKT_LEN);
  localparam logic [CntW-1:0] DepthC  = CntW'(C_FIFO_DEPTH);
  localparam logic [TmrW-1:0] TmrLast = TmrW'(FlushEn ? C_FLUSH_TIMEOUT - 1 : 0);

  pkt_state_e      state_q, state_d;
  logic [CntW-1:0] out_cnt_q, out_cnt_d;
  logic [CntW-1:0] flush_len_q, flush_len_d;
  logic [TmrW-1:0] timer_q, timer_d;
  logic [15:0]     pkt_cnt_q, pkt_cnt_d;
  logic [CntW-1:0] fifo_cnt;
  logic            push, pop, qualify, expire;

  assign S_AXIS_TREADY = !AXIS_ARESET && (state_q != StFlush) && (fifo_cnt < DepthC);
  assign M_AXIS_TVALID = (state_q != StIdle);
  assign M_AXIS_TLAST  = ((state_q == StSend) && (out_cnt_q == PktLenC - CntW'(1))) ||
                         ((state_q == StFlush) && (out_cnt_q == flush_len_q - CntW'(1)));
  assign M_AXIS_TSTRB  = '1;
  assign push = S_AXIS_TVALID && S_AXIS_TREADY;
  assign pop  = M_AXIS_TVALID && M_AXIS_TREADY;

  // Timer only runs while a partial packet sits untouched in IDLE.
  assign qualify = (state_q == StIdle) && (fifo_cnt != '0) && (fifo_cnt < PktLenC) && !push;
  assign expire  = FlushEn && qualify && (timer_q == TmrLast);

  axis_sync_fifo #(
    .Width (C_AXIS_TDATA_WIDTH),
    .Depth (C_FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (AXIS_ACLK),
    .rst_i   (AXIS_ARESET),
    .wdata_i (S_AXIS_TDATA),
    .push_i  (push),
    .pop_i   (pop),
    .rdata_o (M_AXIS_TDATA),
    .count_o (fifo_cnt)
  );

  always_comb begin
    state_d     = state_q;
    out_cnt_d   = out_cnt_q;
    flush_len_d = flush_len_q;
    pkt_cnt_d   = pkt_cnt_q;
    timer_d     = '0;
    unique case (state_q)
      StIdle: begin
        if (fifo_cnt >= PktLenC) begin
          state_d = StSend;
        end else if (expire) begin
          state_d     = StFlush;
          flush_len_d = fifo_cnt;
        end else if (FlushEn && qualify) begin
          timer_d = timer_q + TmrW'(1);
        end
      end
      StSend, StFlush: begin
        if (pop) begin
          if (M_AXIS_TLAST) begin
            out_cnt_d = '0;
            pkt_cnt_d = pkt_cnt_q + 16'd1;
            state_d   = StIdle;
          end else begin
            out_cnt_d = out_cnt_q + CntW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
    if (AXIS_ARESET) begin
      state_q     <= StIdle;
      out_cnt_q   <= '0;
      flush_len_q <= '0;
      timer_q     <= '0;
      pkt_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      out_cnt_q   <= out_cnt_d;
      flush_len_q <= flush_len_d;
      timer_q     <= timer_d;
      pkt_cnt_q   <= pkt_cnt_d;
    end
  end

  assign fifo_count = fifo_cnt;
  assign pkt_count  = pkt_cnt_q;

endmodule
